// File: rtl/serial_to_bus_26.sv
// -----------------------------------------------------------------------------
// serial_to_bus_26
//
// Purpose:
//   Packs a stream of WIDTH-bit words into one 26-lane bus frame and hands the
//   frame downstream. Lane 0 sits in the least-significant slice of the bus.
//   A frame ends after lane 25 is written, or earlier when in_last arrives. A
//   frame that ends early is flagged with bus_short, and its unwritten lanes
//   read as zero.
//
// Ports:
//   clk        in   1          system clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_data    in   WIDTH      stream word
//   in_valid   in   1          in_data is valid
//   in_last    in   1          word ends the frame (qualified by in_valid)
//   in_ready   out  1          block can accept a word (high in FILL)
//   bus_out    out  WIDTH*26   packed frame, lane k at [(k+1)*WIDTH-1 : k*WIDTH]
//   bus_valid  out  1          bus_out holds a complete frame (high in OUT)
//   bus_ready  in   1          consumer accepts the frame
//   bus_short  out  1          frame was ended by in_last before lane 25
//   lane_idx   out  5          next lane to be written (holds the last lane in OUT)
// -----------------------------------------------------------------------------
module serial_to_bus_26 #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [WIDTH*26-1:0]   bus_out,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_short,
  output logic [4:0]            lane_idx
);

  localparam int         LANES     = 26;
  localparam logic [4:0] LAST_LANE = 5'd25;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         lane_idx_q, lane_idx_d;
  logic               short_q, short_d;
  logic               in_ready_q, in_ready_d;
  logic               bus_valid_q, bus_valid_d;

  logic               accept;
  logic               end_frame;
  logic               handshake;

  logic [WIDTH-1:0]   lane_q [LANES];
  logic [LANES-1:0]   lane_wr;

  // ---------------------------------------------------------------------------
  // Handshake decode. Acceptance is keyed on the state register; in_ready_q
  // is a registered copy of the same decode, so the two always agree.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept    = (state_q == FILL) && in_valid;
    end_frame = accept && (in_last || (lane_idx_q == LAST_LANE));
    handshake = (state_q == OUT) && bus_ready;
  end

  // ---------------------------------------------------------------------------
  // Next-state and status logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    short_d    = short_q;

    unique case (state_q)
      FILL: begin
        if (end_frame) begin
          // lane_idx is not advanced on the closing word, so it still points
          // at the last lane written while the frame is presented.
          state_d = OUT;
          short_d = (lane_idx_q != LAST_LANE);
        end else if (accept) begin
          lane_idx_d = lane_idx_q + 5'd1;
        end
      end
      OUT: begin
        if (handshake) begin
          state_d    = FILL;
          lane_idx_d = 5'd0;
          short_d    = 1'b0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    // The flow-control outputs are registered images of the next state. They
    // never depend combinationally on in_valid or bus_ready at the ports.
    in_ready_d  = (state_d == FILL);
    bus_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      lane_idx_q  <= 5'd0;
      short_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      short_q     <= short_d;
      in_ready_q  <= in_ready_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane storage. Each lane has its own write enable. Every lane is cleared at
  // the output handshake so that a short frame that follows reads zero in its
  // unwritten lanes.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_wr[gi] = accept && (lane_idx_q == 5'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_q[gi] <= '0;
        end else if (handshake) begin
          lane_q[gi] <= '0;
        end else if (lane_wr[gi]) begin
          lane_q[gi] <= in_data;
        end
      end

      assign bus_out[gi*WIDTH +: WIDTH] = lane_q[gi];
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign bus_valid = bus_valid_q;
  assign bus_short = short_q;
  assign lane_idx  = lane_idx_q;

endmodule

// File: tb/tb_serial_to_bus_26.sv
// -----------------------------------------------------------------------------
// tb_serial_to_bus_26
//
// Directed testbench for serial_to_bus_26. Each scenario task drives its own
// stimulus and checks the DUT outputs against values the bench computes
// itself. The DUT is sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_to_bus_26;

  localparam int W   = 16;
  localparam int BUS = W * 26;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [BUS-1:0] bus_out;
  logic           bus_valid;
  logic           bus_ready;
  logic           bus_short;
  logic [4:0]     lane_idx;

  int n_checks;
  int n_fail;

  serial_to_bus_26 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_short (bus_short),
    .lane_idx  (lane_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word and hold it until it is accepted. in_ready only changes
  // at clock edges, so its value just before an edge decides that edge.
  task automatic send_word(input logic [W-1:0] d, input logic last);
    logic acc;
    acc      = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    for (int i = 0; i < 200; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_word_timeout: word %h not accepted, got in_ready=%b want 1", d, in_ready);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drive bus_ready for exactly one edge.
  task automatic pulse_bus_ready();
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, bus_valid, bus_short, lane_idx} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b short=%b idx=%0d want 1 0 0 0",
               in_ready, bus_valid, bus_short, lane_idx);
    end
    n_checks++;
    if (bus_out !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h want 0", bus_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    logic [BUS-1:0] exp;
    logic [W-1:0]   lo, hi;
    exp = '0;
    for (int k = 0; k < 26; k++) begin
      exp[k*W +: W] = W'(k + 1);
      send_word(W'(k + 1), 1'b0);
      if (k == 24) begin
        n_checks++;
        if (bus_valid !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_early_valid: got vld=%b rdy=%b want 0 1", bus_valid, in_ready);
        end
      end
    end
    n_checks++;
    if (bus_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_valid_latency: got vld=%b rdy=%b want 1 0", bus_valid, in_ready);
    end
    lo = bus_out[15:0];
    hi = bus_out[415:400];
    n_checks++;
    if (lo !== 16'h0001 || hi !== 16'h001A) begin
      n_fail++;
      $display("FAIL full_edge_lanes: got lane0=%h lane25=%h want 0001 001a", lo, hi);
    end
    n_checks++;
    if (bus_out !== exp) begin
      n_fail++;
      $display("FAIL full_bus: got %h want %h", bus_out, exp);
    end
    n_checks++;
    if (bus_short !== 1'b0 || lane_idx !== 5'd25) begin
      n_fail++;
      $display("FAIL full_status: got short=%b idx=%0d want 0 25", bus_short, lane_idx);
    end
    pulse_bus_ready();
    n_checks++;
    if (in_ready !== 1'b1 || bus_valid !== 1'b0 || lane_idx !== 5'd0 || bus_out !== '0) begin
      n_fail++;
      $display("FAIL full_after_handshake: got rdy=%b vld=%b idx=%0d bus_nonzero=%b want 1 0 0 0",
               in_ready, bus_valid, lane_idx, |bus_out);
    end
    $display("test_full_frame done");
  endtask

  task automatic test_short_frame();
    logic [BUS-1:0] exp;
    exp = '0;
    exp[15:0]  = 16'hAAAA;
    exp[31:16] = 16'hBBBB;
    exp[47:32] = 16'hCCCC;
    send_word(16'hAAAA, 1'b0);
    send_word(16'hBBBB, 1'b0);
    send_word(16'hCCCC, 1'b1);
    n_checks++;
    if (bus_valid !== 1'b1 || bus_short !== 1'b1) begin
      n_fail++;
      $display("FAIL short_flags: got vld=%b short=%b want 1 1", bus_valid, bus_short);
    end
    n_checks++;
    if (bus_out !== exp) begin
      n_fail++;
      $display("FAIL short_bus: got %h want %h", bus_out, exp);
    end
    // Stall one cycle in OUT to confirm lane_idx holds there.
    @(posedge clk); #1;
    n_checks++;
    if (lane_idx !== 5'd2 || bus_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL short_idx_hold: got idx=%0d vld=%b want 2 1", lane_idx, bus_valid);
    end
    pulse_bus_ready();
    n_checks++;
    if (bus_short !== 1'b0 || bus_out !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL short_clear: got short=%b bus_nonzero=%b rdy=%b want 0 0 1",
               bus_short, |bus_out, in_ready);
    end
    $display("test_short_frame done");
  endtask

  task automatic test_backpressure();
    logic [BUS-1:0] exp;
    logic [W-1:0]   l0;
    int             bad;
    exp = '0;
    for (int k = 0; k < 26; k++) begin
      exp[k*W +: W] = W'(16'h0100 + k);
      send_word(W'(16'h0100 + k), 1'b0);
    end
    // Keep a new word on the input while the consumer stalls.
    in_data  = 16'h5555;
    in_valid = 1'b1;
    in_last  = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b0 || bus_valid !== 1'b1 || bus_out !== exp) begin
        n_fail++;
        bad++;
        $display("FAIL bp_stall_cycle%0d: got rdy=%b vld=%b bus=%h want 0 1 %h",
                 c, in_ready, bus_valid, bus_out, exp);
      end
    end
    pulse_bus_ready();
    n_checks++;
    if (in_ready !== 1'b1 || lane_idx !== 5'd0 || bus_out !== '0) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b idx=%0d bus_nonzero=%b want 1 0 0",
               in_ready, lane_idx, |bus_out);
    end
    // The held word is taken on the next edge.
    @(posedge clk); #1;
    in_valid = 1'b0;
    l0 = bus_out[15:0];
    n_checks++;
    if (lane_idx !== 5'd1 || l0 !== 16'h5555) begin
      n_fail++;
      $display("FAIL bp_held_word: got idx=%0d lane0=%h want 1 5555", lane_idx, l0);
    end
    exp = '0;
    exp[15:0] = 16'h5555;
    for (int k = 1; k < 26; k++) begin
      exp[k*W +: W] = W'(16'h0300 + k);
      send_word(W'(16'h0300 + k), 1'b0);
    end
    n_checks++;
    if (bus_valid !== 1'b1 || bus_out !== exp) begin
      n_fail++;
      $display("FAIL bp_next_frame: got vld=%b bus=%h want 1 %h", bus_valid, bus_out, exp);
    end
    pulse_bus_ready();
    $display("test_backpressure done (stall errors %0d)", bad);
  endtask

  task automatic test_input_gaps();
    logic [BUS-1:0] exp;
    int             gap;
    exp = '0;
    for (int k = 0; k < 26; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_data  = 16'hDEAD;
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      n_checks++;
      if (lane_idx !== 5'(k) || bus_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gaps_idx_hold%0d: got idx=%0d vld=%b want %0d 0", k, lane_idx, bus_valid, k);
      end
      exp[k*W +: W] = W'(16'hF000 + 16'h0011 * k);
      send_word(W'(16'hF000 + 16'h0011 * k), 1'b0);
    end
    n_checks++;
    if (bus_valid !== 1'b1 || bus_short !== 1'b0 || bus_out !== exp) begin
      n_fail++;
      $display("FAIL gaps_frame: got vld=%b short=%b bus=%h want 1 0 %h",
               bus_valid, bus_short, bus_out, exp);
    end
    pulse_bus_ready();
    $display("test_input_gaps done");
  endtask

  task automatic test_reset_midframe();
    logic [BUS-1:0] exp;
    for (int k = 0; k < 10; k++) send_word(W'(16'h0E00 + k), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, bus_valid, bus_short, lane_idx} !== {1'b1, 1'b0, 1'b0, 5'd0} || bus_out !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: got rdy=%b vld=%b short=%b idx=%0d bus_nonzero=%b want 1 0 0 0 0",
               in_ready, bus_valid, bus_short, lane_idx, |bus_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp = '0;
    for (int k = 0; k < 26; k++) begin
      exp[k*W +: W] = W'(16'h0200 + k);
      send_word(W'(16'h0200 + k), 1'b0);
    end
    n_checks++;
    if (bus_valid !== 1'b1 || bus_out !== exp) begin
      n_fail++;
      $display("FAIL midreset_clean_frame: got vld=%b bus=%h want 1 %h", bus_valid, bus_out, exp);
    end
    pulse_bus_ready();
    $display("test_reset_midframe done");
  endtask

  task automatic test_back_to_back();
    logic [BUS-1:0] exp;
    send_word(16'h1234, 1'b1);
    exp = '0;
    exp[15:0] = 16'h1234;
    n_checks++;
    if (bus_valid !== 1'b1 || bus_short !== 1'b1 || bus_out !== exp || lane_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_one_word: got vld=%b short=%b idx=%0d bus=%h want 1 1 0 %h",
               bus_valid, bus_short, lane_idx, bus_out, exp);
    end
    // Consumer takes the frame while the next word is already waiting; the
    // word cannot be taken on the handshake edge.
    bus_ready = 1'b1;
    in_data   = 16'h4000;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || lane_idx !== 5'd0 || bus_out !== '0) begin
      n_fail++;
      $display("FAIL b2b_no_same_cycle_accept: got rdy=%b idx=%0d bus=%h want 1 0 0",
               in_ready, lane_idx, bus_out);
    end
    exp = '0;
    for (int k = 0; k < 26; k++) begin
      exp[k*W +: W] = W'(16'h4000 + k);
      send_word(W'(16'h4000 + k), 1'b0);
    end
    n_checks++;
    if (bus_valid !== 1'b1 || bus_short !== 1'b0 || bus_out !== exp) begin
      n_fail++;
      $display("FAIL b2b_full_frame: got vld=%b short=%b bus=%h want 1 0 %h",
               bus_valid, bus_short, bus_out, exp);
    end
    pulse_bus_ready();
    $display("test_back_to_back done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_input_gaps();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
